// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter: derives SCLK/LRCLK from i_clock, double-buffers one
// stereo sample pair and flags underrun/overrun as single-cycle pulses.
`timescale 1ns/1ps
module i2s_transmitter #(
  parameter int DATA_WIDTH       = 24,
  parameter int SLOT_WIDTH       = 32,
  parameter int SCLK_HALF_PERIOD = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data_left,
  input  logic [DATA_WIDTH-1:0] i_data_right,
  input  logic                  i_data_valid,
  output logic                  o_sclk,
  output logic                  o_lrclk,
  output logic                  o_sdata,
  output logic                  o_underrun,
  output logic                  o_overrun
);

  localparam int FRAME_LEN = 2 * SLOT_WIDTH;
  localparam int P_W       = $clog2(FRAME_LEN);
  localparam int H_W       = (SCLK_HALF_PERIOD > 1) ? $clog2(SCLK_HALF_PERIOD) : 1;
  localparam logic [H_W-1:0] H_MAX = H_W'(SCLK_HALF_PERIOD - 1);
  localparam logic [P_W-1:0] P_MAX = P_W'(FRAME_LEN - 1);

  logic [H_W-1:0]        h;
  logic [P_W-1:0]        p;
  logic [DATA_WIDTH-1:0] hold_left, hold_right;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] frame_left, frame_right;

  logic                  h_tick;
  logic                  sclk_fall;
  logic                  frame_load;
  logic [P_W-1:0]        p_next;
  logic                  slot_right;
  logic [31:0]           slot_k;
  logic [DATA_WIDTH-1:0] slot_word;
  logic                  bit_next;

  always_comb begin
    h_tick     = (h == H_MAX);
    sclk_fall  = h_tick && o_sclk;
    p_next     = (p == P_MAX) ? '0 : p + P_W'(1);
    frame_load = sclk_fall && (p == P_MAX);
    slot_right = (p_next >= P_W'(SLOT_WIDTH));
    slot_k     = slot_right ? (32'(p_next) - 32'(SLOT_WIDTH)) : 32'(p_next);
    slot_word  = slot_right ? frame_right : frame_left;
    // Position k in the slot carries word bit DATA_WIDTH-k; k=0 (I2S delay
    // bit) and k>DATA_WIDTH (padding) match no index and stay 0.
    bit_next   = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (slot_k == DATA_WIDTH - i)
        bit_next = slot_word[i];
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      h           <= '0;
      p           <= '0;
      o_sclk      <= 1'b0;
      o_lrclk     <= 1'b0;
      o_sdata     <= 1'b0;
      o_underrun  <= 1'b0;
      o_overrun   <= 1'b0;
      hold_left   <= '0;
      hold_right  <= '0;
      hold_full   <= 1'b0;
      frame_left  <= '0;
      frame_right <= '0;
    end else begin
      o_underrun <= 1'b0;
      o_overrun  <= 1'b0;

      h <= h_tick ? '0 : h + H_W'(1);
      if (h_tick)
        o_sclk <= ~o_sclk;

      if (sclk_fall) begin
        p       <= p_next;
        o_lrclk <= slot_right;
        o_sdata <= bit_next;
      end

      if (frame_load) begin
        if (hold_full) begin
          frame_left  <= hold_left;
          frame_right <= hold_right;
        end else begin
          frame_left  <= '0;
          frame_right <= '0;
          o_underrun  <= 1'b1;
        end
      end

      // A strobe coinciding with a load refills the just-emptied buffer, so
      // full stays set and no overrun is reported.
      if (i_data_valid) begin
        hold_left  <= i_data_left;
        hold_right <= i_data_right;
        hold_full  <= 1'b1;
        if (hold_full && !frame_load)
          o_overrun <= 1'b1;
      end else if (frame_load) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: reconstructs each transmitted frame from
// the serial pins and compares slot words, padding, LRCLK and pulses.
`timescale 1ns/1ps
module tb_i2s_transmitter;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [23:0] i_data_left = '0;
  logic [23:0] i_data_right = '0;
  logic        i_data_valid = 1'b0;
  logic        o_sclk, o_lrclk, o_sdata, o_underrun, o_overrun;

  i2s_transmitter #(
    .DATA_WIDTH(24),
    .SLOT_WIDTH(32),
    .SCLK_HALF_PERIOD(2)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_data_left(i_data_left),
    .i_data_right(i_data_right),
    .i_data_valid(i_data_valid),
    .o_sclk(o_sclk),
    .o_lrclk(o_lrclk),
    .o_sdata(o_sdata),
    .o_underrun(o_underrun),
    .o_overrun(o_overrun)
  );

  always #5 i_clock = ~i_clock;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          bp = 0;
  int          wrap_cyc = 0;
  int          und_cnt = 0;
  int          ovr_cnt = 0;
  logic        prev_sclk = 1'b0;
  logic        wrapped = 1'b0;
  logic [63:0] cur_bits = '0, cur_lr = '0;
  logic [63:0] last_bits = '0, last_lr = '0;
  logic [63:0] pad_mask;
  logic [63:0] lr_exp = {32'hFFFF_FFFF, 32'h0000_0000};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One i_clock cycle; samples on the falling edge and tracks frame position.
  task automatic step();
    @(negedge i_clock);
    wrapped = 1'b0;
    if (i_reset) begin
      prev_sclk = o_sclk;
      return;
    end
    cyc++;
    if (prev_sclk && !o_sclk) begin
      bp = (bp + 1) % 64;
      if (bp == 0) begin
        last_bits = cur_bits;
        last_lr   = cur_lr;
        wrapped   = 1'b1;
        wrap_cyc  = cyc;
      end
      cur_bits[bp] = o_sdata;
      cur_lr[bp]   = o_lrclk;
    end
    prev_sclk = o_sclk;
    if (o_underrun) und_cnt++;
    if (o_overrun)  ovr_cnt++;
  endtask

  task automatic release_reset();
    i_reset   = 1'b0;
    cyc       = 0;
    bp        = 0;
    prev_sclk = 1'b0;
    cur_bits  = '0;
    cur_lr    = '0;
    und_cnt   = 0;
    ovr_cnt   = 0;
  endtask

  task automatic run_to_wrap();
    int n = 0;
    do begin
      step();
      n++;
    end while (!wrapped && n < 400);
    check("wrap_seen", 64'(wrapped), 64'd1);
  endtask

  task automatic strobe(input logic [23:0] l, input logic [23:0] r);
    i_data_left  = l;
    i_data_right = r;
    i_data_valid = 1'b1;
    step();
    i_data_valid = 1'b0;
  endtask

  function automatic logic [23:0] slot_word(input logic [63:0] bits, input int base);
    logic [23:0] w;
    for (int i = 0; i < 24; i++)
      w[23-i] = bits[base+1+i];
    return w;
  endfunction

  task automatic check_frame(input string tag, input logic [23:0] l, input logic [23:0] r);
    check({tag, "_left"},  64'(slot_word(last_bits, 0)),  64'(l));
    check({tag, "_right"}, 64'(slot_word(last_bits, 32)), 64'(r));
    check({tag, "_pad"},   last_bits & pad_mask, 64'd0);
    check({tag, "_lrclk"}, last_lr, lr_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    logic found;
    for (int p = 0; p < 64; p++) begin
      k = p % 32;
      pad_mask[p] = (k == 0 || k > 24);
    end

    // Reset and SCLK start-up
    repeat (3) step();
    check("rst_outputs", 64'({o_sclk, o_lrclk, o_sdata, o_underrun, o_overrun}), 64'd0);
    release_reset();
    step(); check("sclk_c1", 64'(o_sclk), 64'd0);
    step(); check("sclk_c2", 64'(o_sclk), 64'd1);
    step(); check("sclk_c3", 64'(o_sclk), 64'd1);
    step(); check("sclk_c4", 64'(o_sclk), 64'd0);

    // Single sample in the first frame
    strobe(24'hA5F00F, 24'h5A0FF0);
    run_to_wrap();
    check("first_load_cyc", 64'(wrap_cyc), 64'd256);
    check("first_frame_zero", last_bits, 64'd0);
    check("first_no_underrun", 64'(und_cnt), 64'd0);
    run_to_wrap();
    check("second_wrap_cyc", 64'(wrap_cyc), 64'd512);
    check_frame("single", 24'hA5F00F, 24'h5A0FF0);
    check("single_no_overrun", 64'(ovr_cnt), 64'd0);

    // Underrun at the 512 wrap, then an all-zero frame
    check("und_pulse", 64'(o_underrun), 64'd1);
    check("und_count", 64'(und_cnt), 64'd1);
    step();
    check("und_width", 64'(o_underrun), 64'd0);
    run_to_wrap();
    check("underrun_frame", last_bits, 64'd0);
    check("und_count2", 64'(und_cnt), 64'd2);

    // Overrun: second strobe in the same frame wins
    und_cnt = 0;
    ovr_cnt = 0;
    repeat (10) step();
    strobe(24'h111111, 24'h111111);
    check("no_ovr_first", 64'(o_overrun), 64'd0);
    repeat (10) step();
    strobe(24'h222222, 24'h222222);
    check("ovr_pulse", 64'(o_overrun), 64'd1);
    step();
    check("ovr_width", 64'(o_overrun), 64'd0);
    run_to_wrap();
    run_to_wrap();
    check_frame("overrun", 24'h222222, 24'h222222);
    check("ovr_count", 64'(ovr_cnt), 64'd1);
    check("ovr_und_count", 64'(und_cnt), 64'd1);

    // Strobe landing in the exact load cycle
    strobe(24'h333333, 24'h333333);
    und_cnt = 0;
    ovr_cnt = 0;
    while (cyc < 1535) step();
    i_data_left  = 24'h444444;
    i_data_right = 24'h444444;
    i_data_valid = 1'b1;
    step();
    i_data_valid = 1'b0;
    check("simul_is_load", 64'(wrapped), 64'd1);
    run_to_wrap();
    check_frame("simul_first", 24'h333333, 24'h333333);
    check("simul_no_ovr", 64'(ovr_cnt), 64'd0);
    check("simul_no_und", 64'(und_cnt), 64'd0);
    run_to_wrap();
    check_frame("simul_second", 24'h444444, 24'h444444);

    // Extremes, sign bit untouched
    strobe(24'h800000, 24'h7FFFFF);
    run_to_wrap();
    strobe(24'h800000, 24'h7FFFFF);
    run_to_wrap();
    check_frame("extreme", 24'h800000, 24'h7FFFFF);

    // Asynchronous reset mid-frame with a sample pending
    strobe(24'h123456, 24'h654321);
    found = 1'b0;
    n = 0;
    while (!found && n < 300) begin
      step();
      n++;
      found = o_sclk && o_lrclk && o_sdata;
    end
    check("pre_reset_active", 64'(found), 64'd1);
    i_reset = 1'b1;
    #1;
    check("async_reset", 64'({o_sclk, o_lrclk, o_sdata, o_underrun, o_overrun}), 64'd0);
    repeat (3) step();
    release_reset();
    run_to_wrap();
    check("post_rst_wrap_cyc", 64'(wrap_cyc), 64'd256);
    check("post_rst_frame", last_bits, 64'd0);
    check("pending_lost_und", 64'(und_cnt), 64'd1);
    check("post_rst_no_ovr", 64'(ovr_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
